// File: rtl/pc_seq.sv
// Program-counter sequencer for instruction fetch: sequential step, branch,
// jump, and call/return through a small circular return-address stack.
module pc_seq #(
    parameter int               WIDTH     = 16,
    parameter int               STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_jump,
    input  logic             i_call,
    input  logic             i_ret,
    input  logic             i_branch,
    input  logic [WIDTH-1:0] i_jump_addr,
    input  logic [WIDTH-1:0] i_branch_off,
    output logic [WIDTH-1:0] o_pc,
    output logic             o_ras_empty,
    output logic             o_ras_full,
    output logic             o_ras_err
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]    r_wp;
    logic [CW-1:0]    r_cnt;
    logic             r_empty;
    logic             r_full;
    logic             r_err;

    logic [WIDTH-1:0] w_pc_seq;
    logic [WIDTH-1:0] w_pc_next;
    logic [PW-1:0]    w_wp_inc;
    logic [PW-1:0]    w_wp_dec;
    logic [PW-1:0]    w_wp_next;
    logic [CW-1:0]    w_cnt_next;
    logic             w_err_next;
    logic             w_push;

    assign w_pc_seq = r_pc + WIDTH'(STEP);

    // Write pointer always names the next free slot; when full it lands on
    // the oldest entry, so a push there gives circular overwrite for free.
    assign w_wp_inc = (r_wp == PW'(RAS_DEPTH - 1)) ? PW'(0) : r_wp + PW'(1);
    assign w_wp_dec = (r_wp == PW'(0)) ? PW'(RAS_DEPTH - 1) : r_wp - PW'(1);

    // Next-state selection by priority: stall > ret > call > jump > branch > step
    always_comb begin
        w_pc_next  = w_pc_seq;
        w_wp_next  = r_wp;
        w_cnt_next = r_cnt;
        w_err_next = r_err;
        w_push     = 1'b0;
        if (i_stall) begin
            w_pc_next = r_pc;
        end else if (i_ret) begin
            if (r_cnt != CW'(0)) begin
                w_pc_next  = r_ras[w_wp_dec];
                w_wp_next  = w_wp_dec;
                w_cnt_next = r_cnt - CW'(1);
            end else begin
                w_err_next = 1'b1;
            end
        end else if (i_call) begin
            w_push    = 1'b1;
            w_pc_next = i_jump_addr;
            w_wp_next = w_wp_inc;
            if (r_cnt == CW'(RAS_DEPTH)) begin
                w_err_next = 1'b1;
            end else begin
                w_cnt_next = r_cnt + CW'(1);
            end
        end else if (i_jump) begin
            w_pc_next = i_jump_addr;
        end else if (i_branch) begin
            w_pc_next = r_pc + i_branch_off;
        end else begin
            w_pc_next = w_pc_seq;
        end
    end

    // PC, stack pointer, occupancy and flag registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc    <= RESET_VEC;
            r_wp    <= '0;
            r_cnt   <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_pc    <= w_pc_next;
            r_wp    <= w_wp_next;
            r_cnt   <= w_cnt_next;
            r_empty <= (w_cnt_next == CW'(0));
            r_full  <= (w_cnt_next == CW'(RAS_DEPTH));
            r_err   <= w_err_next;
        end
    end

    // Stack storage; contents are meaningless while empty so no reset needed
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_push) begin
            r_ras[r_wp] <= w_pc_seq;
        end
    end

    assign o_pc        = r_pc;
    assign o_ras_empty = r_empty;
    assign o_ras_full  = r_full;
    assign o_ras_err   = r_err;

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer for the instruction-fetch stage; successor to the fixed 5-bit incrementing counter. Adds configurable width, step and reset vector, plus stall, absolute jump, PC-relative branch, and call/return through a small return-address stack (RAS). Drives the instruction-memory address each cycle.

## Interface

- WIDTH, 16, PC and address width in bits
- STEP, 1, sequential increment added to the PC each cycle
- RESET_VEC, 0, PC value loaded on reset
- RAS_DEPTH, 4, return-address stack entries (≥2)

- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- stall  in  1  hold PC and RAS; all other controls ignored
- jump  in  1  load jump_addr
- call  in  1  push PC+STEP, load jump_addr
- ret  in  1  pop RAS top into PC
- branch  in  1  load PC+branch_off
- jump_addr  in  WIDTH  absolute target for jump/call
- branch_off  in  WIDTH  two's-complement offset, relative to current PC
- pc  out  WIDTH  current fetch address (registered)
- ras_empty  out  1  RAS holds 0 entries (registered)
- ras_full  out  1  RAS holds RAS_DEPTH entries (registered)
- ras_err  out  1  sticky: RAS overflow or underflow occurred since reset

## Operation

- Per edge, exactly one action, by priority: reset > stall > ret > call > jump > branch > sequential.
- Reset: pc=RESET_VEC, RAS count=0, ras_empty=1, ras_full=0, ras_err=0. RAS entry contents don't-care.
- Stall: pc, RAS and flags unchanged.
- Sequential: pc ← pc+STEP.
- Branch: pc ← pc+branch_off.
- Jump: pc ← jump_addr; RAS unchanged.
- Call: push (pc+STEP), pc ← jump_addr. When full, the push overwrites the oldest entry (circular), count stays RAS_DEPTH, ras_err←1.
- Ret, RAS non-empty: pc ← top entry, count−1.
- Ret, RAS empty: pc ← pc+STEP (falls through), RAS unchanged, ras_err←1.
- Arithmetic: all PC sums modulo 2^WIDTH; carry-out discarded, no error flagged.
- ras_err clears only on reset.

## Timing

- Controls are sampled at the rising edge. The new pc, flags and RAS state are visible after that edge; one-cycle latency, no combinational input→output paths.
- Back-to-back calls/rets on consecutive cycles are fully supported. A ret in the cycle after a call returns the just-pushed address.
- Reset asserted mid-sequence wins over every other input on that edge, including stall. The RAS is emptied regardless of contents.
- Flag updates coincide with the pc update that caused them.

## Test plan

- Reset/sequential (defaults): hold reset 2 cycles → pc=0x0000, ras_empty=1, ras_err=0. Release → pc=1,2,3 on successive edges. Reassert reset at pc=3 → next pc=0x0000.
- Wrap and branch: jump to 0xFFFF → next pc=0x0000. At pc=0x0010, branch_off=0xFFF8 → pc=0x0008. branch_off=0x0004 → pc=0x000C.
- Call/ret nesting: at pc=0x0100 call 0x0200, at 0x0200 call 0x0300, then ret → pc=0x0201. Ret again → pc=0x0101, ras_empty=1, ras_err=0.
- Overflow/underflow (RAS_DEPTH=4): 5 consecutive calls from pc=0x10,0x20,0x30,0x40,0x50 (each jump_addr equals the next PC) → ras_full=1, ras_err=1. Four rets → 0x51,0x41,0x31,0x21. Fifth ret → pc=old+1, ras_empty=1.
- Priority: assert ret+call+jump+branch together with a non-empty RAS → only the pop occurs. Add stall → pc and RAS held. Add reset → pc=RESET_VEC.
- Parametrised: WIDTH=8, STEP=2, RESET_VEC=0xFE → after reset pc=0xFE, then 0x00, then 0x02.
